regread_stage: RTL and testbench

Register-read/issue stage between decode and execute. Drives the two read ports of the 32×64 register file, captures operands into a valid/ready pipeline register, forwards same-cycle writeback data, and tracks outstanding destination writes in a scoreboard so no instruction leaves with a stale operand. Writeback (the stage feeding the register file write port) reports completions back through the `wb_*` inputs.

---
 rtl/regread_stage.sv | 141 ++++++++++++++
 tb/tb_regread_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regread_stage.sv
// regread_stage: register-read/issue stage between decode and execute.
// Reads two register file ports, resolves operands (x0 hardwired, same-cycle
// writeback bypass), tracks outstanding destination writes in a scoreboard to
// block RAW/WAW hazards, and holds the result in a valid/ready output register.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      decode handshake (in_ready_o combinational)
//   in_rs1_i, in_rs2_i, in_rd_i  source/destination register addresses
//   in_rd_we_i, in_ctrl_i        destination write enable, opaque control
//   rf_read_addr{1,2}_o          register file read addresses (combinational)
//   rf_read_data{1,2}_i          register file combinational read data
//   wb_en_i, wb_addr_i, wb_data_i  writeback commit (also feeds the bypass)
//   out_valid_o / out_ready_i    execute handshake
//   out_op1_o, out_op2_o, out_rd_o, out_rd_we_o, out_ctrl_o  registered payload
module regread_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_rs1_i,
    input  logic [ADDR_W-1:0] in_rs2_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic              in_rd_we_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic [ADDR_W-1:0] rf_read_addr1_o,
    output logic [ADDR_W-1:0] rf_read_addr2_o,
    input  logic [DATA_W-1:0] rf_read_data1_i,
    input  logic [DATA_W-1:0] rf_read_data2_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_op1_o,
    output logic [DATA_W-1:0] out_op2_o,
    output logic [ADDR_W-1:0] out_rd_o,
    output logic              out_rd_we_o,
    output logic [CTRL_W-1:0] out_ctrl_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;
    logic              wb_hit;
    logic              fwd1;
    logic              fwd2;
    logic              busy1;
    logic              busy2;
    logic              busy_rd;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] op1_c;
    logic [DATA_W-1:0] op2_c;

    // Register file addresses come straight from decode.
    assign rf_read_addr1_o = in_rs1_i;
    assign rf_read_addr2_o = in_rs2_i;

    // Operand resolution and hazard detection.
    always_comb begin
        wb_hit  = wb_en_i && (wb_addr_i != '0);
        fwd1    = wb_hit && (wb_addr_i == in_rs1_i);
        fwd2    = wb_hit && (wb_addr_i == in_rs2_i);

        // A register being written back this cycle is no longer busy.
        busy1   = pending_q[in_rs1_i] && !fwd1;
        busy2   = pending_q[in_rs2_i] && !fwd2;
        busy_rd = pending_q[in_rd_i] && !(wb_hit && (wb_addr_i == in_rd_i));

        hazard  = busy1 || busy2 || (in_rd_we_i && busy_rd);

        in_ready_o = (!out_valid_o || out_ready_i) && !hazard;
        accept     = in_valid_i && in_ready_o;

        if (in_rs1_i == '0) begin
            op1_c = '0;
        end else if (fwd1) begin
            op1_c = wb_data_i;
        end else begin
            op1_c = rf_read_data1_i;
        end

        if (in_rs2_i == '0) begin
            op2_c = '0;
        end else if (fwd2) begin
            op2_c = wb_data_i;
        end else begin
            op2_c = rf_read_data2_i;
        end
    end

    // Scoreboard next state: clear on writeback, then set on accept so a new
    // producer of the same register stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (wb_hit) begin
            pending_d[wb_addr_i] = 1'b0;
        end
        if (accept && in_rd_we_i && (in_rd_i != '0)) begin
            pending_d[in_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Output pipeline register: load on accept, drain on ready, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_op1_o   <= '0;
            out_op2_o   <= '0;
            out_rd_o    <= '0;
            out_rd_we_o <= 1'b0;
            out_ctrl_o  <= '0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_op1_o   <= op1_c;
            out_op2_o   <= op2_c;
            out_rd_o    <= in_rd_i;
            out_rd_we_o <= in_rd_we_i;
            out_ctrl_o  <= in_ctrl_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regread_stage.sv
// Testbench for regread_stage: directed scenarios with literal expectations,
// plus a per-cycle comparison against an architectural model of the stage.
module tb_regread_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        in_rd_we = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [63:0] rf_d1;
    logic [63:0] rf_d2;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_op1;
    logic [63:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] out_ctrl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regread_stage dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rd_i(in_rd),
        .in_rd_we_i(in_rd_we), .in_ctrl_i(in_ctrl),
        .rf_read_addr1_o(rf_a1), .rf_read_addr2_o(rf_a2),
        .rf_read_data1_i(rf_d1), .rf_read_data2_i(rf_d2),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_op1_o(out_op1), .out_op2_o(out_op2), .out_rd_o(out_rd),
        .out_rd_we_o(out_rd_we), .out_ctrl_o(out_ctrl)
    );

    // Register file: combinational read, written by writeback (r0 storage
    // is writable so the stage's x0 hardwiring is exercised).
    logic [63:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    assign rf_d1 = rf[rf_a1];
    assign rf_d2 = rf[rf_a2];
    always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

    // Architectural model: which registers have an outstanding producer, and
    // the instruction currently held for execute.
    bit          m_pend [32];
    bit          m_valid;
    logic [63:0] m_op1;
    logic [63:0] m_op2;
    logic [4:0]  m_rd;
    bit          m_we;
    logic [15:0] m_ctrl;

    // Value of register r as seen by an instruction issuing this cycle.
    function automatic logic [63:0] m_val(input logic [4:0] r);
        if (r == 5'd0) return 64'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return rf[r];
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = m_busy(in_rs1) || m_busy(in_rs2) || (in_rd_we && m_busy(in_rd));
        return (!m_valid || out_ready) && !haz;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_pend[wb_addr] <= 1'b0;
            if (in_valid && m_ready()) begin
                if (in_rd_we && in_rd != 5'd0) m_pend[in_rd] <= 1'b1;
                m_valid <= 1'b1;
                m_op1   <= m_val(in_rs1);
                m_op2   <= m_val(in_rs2);
                m_rd    <= in_rd;
                m_we    <= in_rd_we;
                m_ctrl  <= in_ctrl;
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_in_ready", 64'(in_ready), 64'(m_ready()));
            chk("m_rf_addr1", 64'(rf_a1), 64'(in_rs1));
            chk("m_rf_addr2", 64'(rf_a2), 64'(in_rs2));
            chk("m_out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("m_op1", out_op1, m_op1);
                chk("m_op2", out_op2, m_op2);
                chk("m_rd", 64'(out_rd), 64'(m_rd));
                chk("m_rd_we", 64'(out_rd_we), 64'(m_we));
                chk("m_ctrl", 64'(out_ctrl), 64'(m_ctrl));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic [15:0] ctrl);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        in_ctrl  = ctrl;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    initial begin
        // Reset then idle.
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_op1", out_op1, 64'd0);
        chk("rst_op2", out_op2, 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_we", 64'(out_rd_we), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);

        // Preload r20, r5, and r0 storage through the write port.
        tick();
        wb(5'd20, 64'hCAFEBABECAFEBABE); tick();
        wb(5'd5,  64'hDECADEFACADECAFE); tick();
        wb(5'd0,  64'h1234567887654321); tick();
        wb_en = 1'b0;

        // Plain read.
        issue(5'd20, 5'd5, 5'd1, 1'b0, 16'hA5A5); tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("read_valid", 64'(out_valid), 64'd1);
        chk("read_op1", out_op1, 64'hCAFEBABECAFEBABE);
        chk("read_op2", out_op2, 64'hDECADEFACADECAFE);
        chk("read_ctrl", 64'(out_ctrl), 64'hA5A5);

        // RAW: producer of r19, then consumer waits for its writeback.
        tick();
        issue(5'd0, 5'd0, 5'd19, 1'b1, 16'h0001); tick();
        issue(5'd19, 5'd0, 5'd2, 1'b1, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("raw_stall", 64'(in_ready), 64'd0);
            tick();
        end
        wb(5'd19, 64'hCAFEBABE12345678);
        @(negedge clk);
        chk("raw_wb_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        chk("raw_bypass_op1", out_op1, 64'hCAFEBABE12345678);
        wb(5'd2, 64'h2222); tick();
        wb_en = 1'b0;

        // x0: reads are zero regardless of storage; rd=0 is never pending.
        issue(5'd0, 5'd0, 5'd0, 1'b1, 16'h0003); tick();
        issue(5'd0, 5'd20, 5'd0, 1'b0, 16'h0004);
        @(negedge clk);
        chk("x0_op1", out_op1, 64'd0);
        chk("x0_op2", out_op2, 64'd0);
        chk("x0_no_stall", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;

        // Backpressure: hold A for 3 cycles while B waits.
        issue(5'd20, 5'd5, 5'd0, 1'b0, 16'h1111); tick();
        out_ready = 1'b0;
        issue(5'd5, 5'd20, 5'd0, 1'b0, 16'h2222);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_ctrl", 64'(out_ctrl), 64'h1111);
            chk("bp_op1", out_op1, 64'hCAFEBABECAFEBABE);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_b_ctrl", 64'(out_ctrl), 64'h2222);
        chk("bp_b_op1", out_op1, 64'hDECADEFACADECAFE);

        // WAW on r23, with set winning over a same-cycle clear.
        tick();
        issue(5'd0, 5'd0, 5'd23, 1'b1, 16'h0023); tick();
        issue(5'd0, 5'd0, 5'd23, 1'b1, 16'h0024);
        @(negedge clk);
        chk("waw_stall", 64'(in_ready), 64'd0);
        tick();
        wb(5'd23, 64'h23);
        @(negedge clk);
        chk("waw_accept", 64'(in_ready), 64'd1);
        tick();
        wb_en = 1'b0;
        issue(5'd23, 5'd0, 5'd0, 1'b0, 16'h0025);
        @(negedge clk);
        chk("waw_still_pending", 64'(in_ready), 64'd0);
        tick();
        wb(5'd23, 64'h0000_0000_0000_2323);
        @(negedge clk);
        chk("waw_clear_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        wb_en = 1'b0;
        @(negedge clk);
        chk("waw_bypass_op1", out_op1, 64'h2323);

        // Reset mid-stream with r5 pending.
        tick();
        issue(5'd0, 5'd0, 5'd5, 1'b1, 16'h0005); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        issue(5'd5, 5'd0, 5'd6, 1'b0, 16'h0006);
        @(negedge clk);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_op1", out_op1, 64'hDECADEFACADECAFE);

        // Mixed traffic checked against the model every cycle.
        for (int i = 0; i < 60; i++) begin
            tick();
            issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  16'($urandom));
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            wb_en     = 1'($urandom_range(0, 1));
            wb_addr   = 5'($urandom_range(0, 31));
            wb_data   = {32'($urandom), 32'($urandom)};
        end
        tick();
        in_valid = 1'b0;
        wb_en = 1'b0;
        out_ready = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
